// File: rtl/mem_stage_pkg.sv
// +----------------------------------------------------------------------+
// | mem_stage_pkg : shared constants and types for the RV32I MEM stage    |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

package mem_stage_pkg;

  localparam logic [6:0] c_OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] c_OPC_STORE = 7'b0100011;

  localparam logic [2:0] c_F3_LB  = 3'b000;
  localparam logic [2:0] c_F3_LH  = 3'b001;
  localparam logic [2:0] c_F3_LW  = 3'b010;
  localparam logic [2:0] c_F3_LBU = 3'b100;
  localparam logic [2:0] c_F3_LHU = 3'b101;
  localparam logic [2:0] c_F3_SB  = 3'b000;
  localparam logic [2:0] c_F3_SH  = 3'b001;
  localparam logic [2:0] c_F3_SW  = 3'b010;

  localparam logic [1:0] c_WD_C    = 2'd0;
  localparam logic [1:0] c_WD_LOAD = 2'd1;
  localparam logic [1:0] c_WD_PC4  = 2'd2;
  localparam logic [1:0] c_WD_IMM  = 2'd3;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUS  = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/mem_stage_lsu_align.sv
// +----------------------------------------------------------------------+
// | lsu_align : store strobe/data replication and load byte/half extract  |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module lsu_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  strb,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    strb  = 4'b1111;
    wdata = store_data;
    case (funct3)
      c_F3_SB: begin
        strb  = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      c_F3_SH: begin
        strb  = 4'b0011 << addr_lo;
        wdata = {2{store_data[15:0]}};
      end
      c_F3_SW: begin
        strb  = 4'b1111;
        wdata = store_data;
      end
      default: begin
        strb  = 4'b1111;
        wdata = store_data;
      end
    endcase
  end

  always_comb begin
    w_byte = rdata[7:0];
    case (addr_lo)
      2'd0:    w_byte = rdata[7:0];
      2'd1:    w_byte = rdata[15:8];
      2'd2:    w_byte = rdata[23:16];
      default: w_byte = rdata[31:24];
    endcase
    w_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    load_data = rdata;
    case (funct3)
      c_F3_LB:  load_data = {{24{w_byte[7]}}, w_byte};
      c_F3_LH:  load_data = {{16{w_half[15]}}, w_half};
      c_F3_LW:  load_data = rdata;
      c_F3_LBU: load_data = {24'd0, w_byte};
      c_F3_LHU: load_data = {16'd0, w_half};
      default:  load_data = rdata;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
// +----------------------------------------------------------------------+
// | mem_stage : RV32I MEM stage with req/ack bus, timeout and MEM/WB regs |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] C_i,
  input  logic [31:0] rD2_i,
  input  logic        wr_i_i,
  input  logic [31:0] inst_i,
  input  logic        bubble_i,
  input  logic [1:0]  wD_sel_i,
  input  logic [31:0] pc4_i,
  input  logic [31:0] imm_i,
  input  logic        RegWrite_i,
  output logic        stall_o,
  output logic        req_o,
  output logic        we_o,
  output logic [31:0] addr_o,
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb_o,
  input  logic        ack_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] wD_o,
  output logic [4:0]  rd_o,
  output logic        RegWrite_o,
  output logic        bubble_o,
  output logic        trap_o,
  output logic        bus_err_o
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic        w_is_load;
  logic        w_mem_op;
  logic        w_misaligned;
  logic [3:0]  w_strb;
  logic [31:0] w_load_data;
  logic [31:0] w_wd;
  logic        w_load_slot;
  logic        w_take_bubble;
  logic        w_trap_nxt;
  logic        w_err_nxt;
  logic        w_unused;

  assign w_unused = &{1'b0, inst_i[31:15]};

  assign w_opcode  = inst_i[6:0];
  assign w_funct3  = inst_i[14:12];
  assign w_is_load = (w_opcode == c_OPC_LOAD);
  assign w_mem_op  = !bubble_i && (w_is_load || wr_i_i);

  // funct3[1:0] encodes access size for both loads and stores
  assign w_misaligned = ((w_funct3[1:0] == 2'b01) && C_i[0]) ||
                        ((w_funct3[1:0] == 2'b10) && (C_i[1:0] != 2'b00));

  lsu_align u_lsu_align (
    .addr_lo    (C_i[1:0]),
    .funct3     (w_funct3),
    .store_data (rD2_i),
    .rdata      (rdata_i),
    .strb       (w_strb),
    .wdata      (wdata_o),
    .load_data  (w_load_data)
  );

  assign addr_o  = {C_i[31:2], 2'b00};
  assign we_o    = req_o && wr_i_i;
  assign wstrb_o = (req_o && wr_i_i) ? w_strb : 4'b0000;

  always_comb begin
    w_wd = C_i;
    case (wD_sel_i)
      c_WD_C:    w_wd = C_i;
      c_WD_LOAD: w_wd = (w_is_load && !wr_i_i) ? w_load_data : 32'd0;
      c_WD_PC4:  w_wd = pc4_i;
      c_WD_IMM:  w_wd = imm_i;
      default:   w_wd = C_i;
    endcase
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    stall_o       = 1'b0;
    req_o         = 1'b0;
    w_load_slot   = 1'b0;
    w_take_bubble = 1'b0;
    w_trap_nxt    = 1'b0;
    w_err_nxt     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_mem_op) begin
          w_load_slot = 1'b1;
        end else if (w_misaligned) begin
          w_take_bubble = 1'b1;
          w_trap_nxt    = 1'b1;
        end else begin
          stall_o       = 1'b1;
          w_take_bubble = 1'b1;
          w_state_nxt   = S_BUS;
        end
      end
      S_BUS: begin
        req_o = 1'b1;
        if (ack_i) begin
          w_load_slot = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else if (r_cnt < c_CNT_LAST) begin
          stall_o       = 1'b1;
          w_take_bubble = 1'b1;
          w_cnt_nxt     = r_cnt + 1'b1;
        end else begin
          w_err_nxt     = 1'b1;
          w_take_bubble = 1'b1;
          w_cnt_nxt     = '0;
          w_state_nxt   = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      wD_o       <= 32'd0;
      rd_o       <= 5'd0;
      RegWrite_o <= 1'b0;
      bubble_o   <= 1'b1;
      trap_o     <= 1'b0;
      bus_err_o  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      trap_o    <= w_trap_nxt;
      bus_err_o <= w_err_nxt;
      if (w_load_slot) begin
        wD_o       <= w_wd;
        rd_o       <= inst_i[11:7];
        // a store never writes the register file
        RegWrite_o <= RegWrite_i && !bubble_i && !wr_i_i;
        bubble_o   <= bubble_i;
      end else if (w_take_bubble) begin
        RegWrite_o <= 1'b0;
        bubble_o   <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire
